pac_rr_requester: RTL and testbench

Client-side request agent for the PAC-RR arbiter. It buffers command beats from a local master in a small FIFO and raises `req_o` toward the arbiter once a complete burst is queued. After the grant arrives, it drives the burst onto the shared source channel with a valid/ready handshake. One instance sits in front of each arbiter request line, so it is the initiator end of the arbiter's req/grant and valid/ready protocol.

---
 rtl/pac_rr_requester.sv | 162 ++++++++++++++++
 tb/tb_pac_rr_requester.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pac_rr_requester.sv
// Client request agent for the PAC-RR arbiter: queues beats, requests once a burst is ready, streams it on grant.
// Latency: req_o follows the state register one edge after a complete burst is queued; first beat one edge after grant.
// Backpressure: cmd_ready_o drops when the FIFO is full, and sink_ready_i stalls the held beat. PAC_RR_REQ_TIMEOUT_EN adds a grant watchdog.
module pac_rr_requester #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [DATA_W-1:0]      cmd_data_i,
  input  logic                   cmd_last_i,
  output logic                   req_o,
  input  logic                   grant_i,
  output logic                   src_valid_o,
  output logic [DATA_W-1:0]      src_data_o,
  output logic                   src_last_o,
  input  logic                   sink_ready_i,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   timeout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] LAST_BEAT = LW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [LW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              push, pop, burst_rdy, burst_end;

  assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
  assign head_last = mem_q[rd_ptr_q][DATA_W];

  // src_valid_o looks only at state, grant and occupancy so the sink's ready never loops back into valid.
  always_comb begin
    req_o       = (state_q != ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    src_valid_o = (state_q == ST_XFER) && grant_i && (level_q != '0);
    burst_end   = head_last || (beat_cnt_q == LAST_BEAT);
    src_last_o  = src_valid_o && burst_end;
    src_data_o  = src_valid_o ? head_data : '0;
    cmd_ready_o = (level_q != FULL_LVL);
    level_o     = level_q;
    push        = cmd_valid_i && cmd_ready_o;
    pop         = src_valid_o && sink_ready_i;
    // A full FIFO with no packet end still has to drain, otherwise the client stalls forever.
    burst_rdy   = (pkt_cnt_q != '0) || (level_q == FULL_LVL);
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    pkt_cnt_d  = pkt_cnt_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    unique case ({push && cmd_last_i, pop && head_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + LW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - LW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (burst_rdy) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant_i) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (pop) begin
          if (burst_end) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + LW'(1);
          end
        end else if (!grant_i) begin
          // Grant lost mid-burst: keep beat_cnt so the resumed burst still honours MAX_BURST.
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_last_i, cmd_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef PAC_RR_REQ_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       to_q, to_d;

  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (state_d != ST_REQ) begin
      wd_d = '0;
    end else if ((state_q == ST_REQ) && !grant_i && (wd_q != 8'hFF)) begin
      wd_d = wd_q + 8'd1;
    end
    if (wd_d == 8'hFF) to_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pac_rr_requester.sv
// Bench for pac_rr_requester: directed scenarios plus a randomized run checked against a queue model of the FIFO and burst rules.
module tb_pac_rr_requester;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 4;
`ifdef PAC_RR_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_last;
  logic [DATA_W-1:0] cmd_data;
  logic              req, grant;
  logic              src_valid, src_last, sink_ready;
  logic [DATA_W-1:0] src_data;
  logic              busy, timeout;
  logic [2:0]        level;

  int total = 0;
  int bad   = 0;

  pac_rr_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data), .cmd_last_i(cmd_last),
    .req_o(req), .grant_i(grant),
    .src_valid_o(src_valid), .src_data_o(src_data), .src_last_o(src_last), .sink_ready_i(sink_ready),
    .busy_o(busy), .level_o(level), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_last = 1'b0; cmd_data = '0; grant = 1'b0; sink_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic l);
    cmd_valid = 1'b1; cmd_data = d; cmd_last = l;
    tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    #1;
  endtask

  task automatic wait_req(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (req) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (src_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_last = 1'b0; cmd_data = '0; grant = 1'b0; sink_ready = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", req); end
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL rst_src_valid got=%0b exp=0", src_valid); end
    total++; if (src_last !== 1'b0) begin bad++; $display("FAIL rst_src_last got=%0b exp=0", src_last); end
    total++; if (src_data !== 8'h00) begin bad++; $display("FAIL rst_src_data got=%0h exp=0", src_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b exp=0", timeout); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] exp [3];
    bit ok;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    grant = 1'b1; sink_ready = 1'b1;
    push_beat(exp[0], 1'b0); push_beat(exp[1], 1'b0); push_beat(exp[2], 1'b1);
    wait_req(6, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_req got=0 exp=1 within 6 cycles"); end
    wait_valid(6, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_first_valid got=0 exp=1 within 6 cycles"); end
    for (int k = 0; k < 3; k++) begin
      total++; if (src_valid !== 1'b1) begin bad++; $display("FAIL basic_valid beat%0d got=%0b exp=1", k, src_valid); end
      total++; if (src_data !== exp[k]) begin bad++; $display("FAIL basic_data beat%0d got=%0h exp=%0h", k, src_data, exp[k]); end
      total++; if (src_last !== (k == 2)) begin bad++; $display("FAIL basic_last beat%0d got=%0b exp=%0b", k, src_last, (k == 2)); end
      tick();
    end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL basic_req_drop got=%0b exp=0", req); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL basic_level got=%0d exp=0", level); end
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] d [4];
    bit ok;
    grant = 1'b0; sink_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d[k] = 8'($urandom);
      push_beat(d[k], 1'b0);
    end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL flush_full_ready got=%0b exp=0", cmd_ready); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL flush_full_level got=%0d exp=4", level); end
    push_beat(8'hEE, 1'b1);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL flush_push_full_level got=%0d exp=4", level); end
    wait_req(6, ok);
    total++; if (!ok) begin bad++; $display("FAIL flush_req got=0 exp=1 within 6 cycles"); end
    grant = 1'b1;
    #1;
    wait_valid(6, ok);
    total++; if (!ok) begin bad++; $display("FAIL flush_first_valid got=0 exp=1 within 6 cycles"); end
    for (int k = 0; k < 4; k++) begin
      total++; if (src_valid !== 1'b1) begin bad++; $display("FAIL flush_valid beat%0d got=%0b exp=1", k, src_valid); end
      total++; if (src_data !== d[k]) begin bad++; $display("FAIL flush_data beat%0d got=%0h exp=%0h", k, src_data, d[k]); end
      total++; if (src_last !== (k == 3)) begin bad++; $display("FAIL flush_last beat%0d got=%0b exp=%0b", k, src_last, (k == 3)); end
      tick();
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL flush_level_end got=%0d exp=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_end got=%0b exp=0", busy); end
  endtask

  task automatic test_grant_drop();
    logic [DATA_W-1:0] d [3];
    bit ok;
    grant = 1'b1; sink_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d[k] = 8'($urandom);
      push_beat(d[k], k == 2);
    end
    wait_valid(8, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_first_valid got=0 exp=1 within 8 cycles"); end
    total++; if (src_data !== d[0]) begin bad++; $display("FAIL drop_beat0_data got=%0h exp=%0h", src_data, d[0]); end
    total++; if (src_last !== 1'b0) begin bad++; $display("FAIL drop_beat0_last got=%0b exp=0", src_last); end
    tick();
    grant = 1'b0;
    #1;
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL drop_valid_same_cycle got=%0b exp=0", src_valid); end
    tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL drop_req_held got=%0b exp=1", req); end
    total++; if (level !== 3'd2) begin bad++; $display("FAIL drop_level got=%0d exp=2", level); end
    tick();
    grant = 1'b1;
    #1;
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL drop_in_req_valid got=%0b exp=0", src_valid); end
    wait_valid(4, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_resume_valid got=0 exp=1 within 4 cycles"); end
    for (int k = 1; k < 3; k++) begin
      total++; if (src_data !== d[k]) begin bad++; $display("FAIL drop_resume_data beat%0d got=%0h exp=%0h", k, src_data, d[k]); end
      total++; if (src_last !== (k == 2)) begin bad++; $display("FAIL drop_resume_last beat%0d got=%0b exp=%0b", k, src_last, (k == 2)); end
      tick();
    end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL drop_req_end got=%0b exp=0", req); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d [3];
    bit ok;
    grant = 1'b1; sink_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[k] = 8'($urandom);
      push_beat(d[k], k == 2);
    end
    wait_valid(8, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_first_valid got=0 exp=1 within 8 cycles"); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (src_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held cyc%0d got=%0b exp=1", c, src_valid); end
      total++; if (src_data !== d[0]) begin bad++; $display("FAIL bp_data_stable cyc%0d got=%0h exp=%0h", c, src_data, d[0]); end
      total++; if (level !== 3'd3) begin bad++; $display("FAIL bp_no_pop cyc%0d got=%0d exp=3", c, level); end
    end
    sink_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (src_data !== d[k]) begin bad++; $display("FAIL bp_drain_data beat%0d got=%0h exp=%0h", k, src_data, d[k]); end
      total++; if (src_last !== (k == 2)) begin bad++; $display("FAIL bp_drain_last beat%0d got=%0b exp=%0b", k, src_last, (k == 2)); end
      tick();
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL bp_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    grant = 1'b1; sink_ready = 1'b1;
    push_beat(8'hA1, 1'b0); push_beat(8'hA2, 1'b0); push_beat(8'hA3, 1'b1);
    wait_valid(8, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_first_valid got=0 exp=1 within 8 cycles"); end
    tick();
    total++; if (level !== 3'd2) begin bad++; $display("FAIL rmid_level_before got=%0d exp=2", level); end
    rst = 1'b1;
    tick();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%0b exp=0", req); end
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL rmid_src_valid got=%0b exp=0", src_valid); end
    total++; if (src_last !== 1'b0) begin bad++; $display("FAIL rmid_src_last got=%0b exp=0", src_last); end
    total++; if (src_data !== 8'h00) begin bad++; $display("FAIL rmid_src_data got=%0h exp=0", src_data); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rmid_level got=%0d exp=0", level); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_cmd_ready got=%0b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    rst = 1'b0;
    tick(); tick(); tick();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rmid_no_rerequest got=%0b exp=0", req); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    sink_ready = 1'b1; grant = 1'b0;
    push_beat(8'h5A, 1'b1);
    wait_req(6, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_req got=0 exp=1 within 6 cycles"); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%0b exp=0", timeout); end
    repeat (260) tick();
    total++; if (timeout !== TO_EN) begin bad++; $display("FAIL to_after_260 got=%0b exp=%0b", timeout, TO_EN); end
    total++; if (req !== 1'b1) begin bad++; $display("FAIL to_still_req got=%0b exp=1", req); end
    grant = 1'b1;
    #1;
    wait_valid(4, ok);
    total++; if (src_data !== 8'h5A) begin bad++; $display("FAIL to_beat_data got=%0h exp=5a", src_data); end
    tick();
    total++; if (timeout !== TO_EN) begin bad++; $display("FAIL to_sticky got=%0b exp=%0b", timeout, TO_EN); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL to_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_random();
    logic [DATA_W:0]   q [$];
    logic [DATA_W-1:0] hold_dat;
    int  bcnt;
    bit  hold, sent_last, psh, pp, exp_last;
    do_reset();
    bcnt = 0; hold = 1'b0; sent_last = 1'b0;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      if (cyc < 1400) begin
        cmd_valid  = ($urandom_range(0, 2) != 0);
        cmd_last   = ($urandom_range(0, 3) == 0);
        grant      = ($urandom_range(0, 7) != 0);
        sink_ready = ($urandom_range(0, 3) != 0);
      end else begin
        cmd_valid  = !sent_last;
        cmd_last   = 1'b1;
        grant      = 1'b1;
        sink_ready = 1'b1;
      end
      cmd_data = 8'($urandom);
      #1;
      total++; if (int'(level) != q.size()) begin bad++; $display("FAIL rnd_level cyc%0d got=%0d exp=%0d", cyc, level, q.size()); end
      total++; if (cmd_ready !== (q.size() != DEPTH)) begin bad++; $display("FAIL rnd_cmd_ready cyc%0d got=%0b exp=%0b", cyc, cmd_ready, (q.size() != DEPTH)); end
      if (src_valid) begin
        total++; if (!grant || q.size() == 0) begin bad++; $display("FAIL rnd_valid_legal cyc%0d got=1 exp=0 (grant=%0b size=%0d)", cyc, grant, q.size()); end
        if (q.size() > 0) begin
          exp_last = q[0][DATA_W] || (bcnt == MAX_BURST - 1);
          total++; if (src_data !== q[0][DATA_W-1:0]) begin bad++; $display("FAIL rnd_data cyc%0d got=%0h exp=%0h", cyc, src_data, q[0][DATA_W-1:0]); end
          total++; if (src_last !== exp_last) begin bad++; $display("FAIL rnd_last cyc%0d got=%0b exp=%0b", cyc, src_last, exp_last); end
        end
      end
      if (hold && grant) begin
        total++; if (src_valid !== 1'b1 || src_data !== hold_dat) begin bad++; $display("FAIL rnd_stable cyc%0d got=%0b/%0h exp=1/%0h", cyc, src_valid, src_data, hold_dat); end
      end
      psh = cmd_valid && (q.size() != DEPTH);
      pp  = src_valid && sink_ready && (q.size() > 0);
      if (pp) begin
        exp_last = q[0][DATA_W] || (bcnt == MAX_BURST - 1);
        void'(q.pop_front());
        bcnt = exp_last ? 0 : bcnt + 1;
      end
      if (psh) begin
        q.push_back({cmd_last, cmd_data});
        if (cyc >= 1400) sent_last = 1'b1;
      end
      hold     = src_valid && !sink_ready;
      hold_dat = src_data;
      tick();
    end
    cmd_valid = 1'b0;
    #1;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rnd_drained got=%0d exp=0", level); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rnd_idle_req got=%0b exp=0", req); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_grant_drop();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
